dmem_bus_arbiter: RTL
=====================

// Module: dmem_bus_arbiter
// PURPOSE
// Shares the single data-memory port among NUM_REQ per-core L1 cache miss/write-through ports.
// Sits between the L1 caches' dmem_* interfaces and the shared data memory.
// Grants one transaction at a time using round-robin order.
// Returns read data and a one-cycle ack to the winning requester; requesters stall until they see the ack.
// PARAMETERS
// NUM_REQ  2   number of requesters (cores); legal range 2..8
// ADDR_W   10  dmem word address width
// DATA_W   32  data width
// MEM_LAT  1   dmem read latency: cycles from enable cycle to data valid; legal >=1
// PORTS
// clk         in   1                 rising-edge clock
// reset       in   1                 asynchronous, active-low reset
// req_rd      in   NUM_REQ           per-requester read request, level; held until ack
// req_wr      in   NUM_REQ           per-requester write request, level; held until ack
// req_addr    in   NUM_REQ x ADDR_W  per-requester address
// req_wdata   in   NUM_REQ x DATA_W  per-requester write data
// req_gnt     out  NUM_REQ           one-hot; owner of the transaction in flight
// req_ack     out  NUM_REQ           one-cycle completion pulse
// req_rdata   out  DATA_W            read data; valid in the req_ack cycle; held until next read capture
// dmem_rd_en  out  1                 memory read strobe, one cycle per read
// dmem_wr_en  out  1                 memory write strobe, one cycle per write
// dmem_address out ADDR_W            memory address; valid while strobe high
// data_to_dmem out DATA_W            memory write data; valid while dmem_wr_en high
// data_from_dmem in DATA_W           memory read data
// BEHAVIOUR
// Reset (reset==0, async): every output goes to 0 immediately.
//   - FSM returns to IDLE; rr_ptr=0; latched request dropped.
//   - An in-flight transaction is abandoned: no ack and no strobe after reset release.
// FSM: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
// IDLE: if any requester has req_rd|req_wr, pick the first active requester searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//   - Latch that requester's op, addr and wdata; set req_gnt; go to ACCESS.
//   - With no request, stay in IDLE.
// Same requester with rd and wr both high: treated as a write; the read is not performed.
// ACCESS (1 cycle): drive dmem_rd_en or dmem_wr_en = 1 from the latched registers, not live inputs.
//   - Load lat_cnt=MEM_LAT; go to WAIT.
// WAIT (MEM_LAT cycles): strobes 0; decrement lat_cnt.
//   - On the last WAIT cycle (lat_cnt==1), a read captures data_from_dmem into req_rdata at the clock edge.
//   - Then go to RESP.
// RESP (1 cycle): req_ack[gnt]=1; rr_ptr <= gnt+1 (mod NUM_REQ); clear req_gnt at the exit edge; go to IDLE.
// Latency: request visible in IDLE cycle t -> strobe at t+1 -> ack at t+2+MEM_LAT. Reads and writes are identical.
// Throughput: one transaction per 3+MEM_LAT cycles; back-to-back requesters alternate strictly.
// Requests changing or dropping after the IDLE sample are ignored; the transaction completes and acks.
// A requester must deassert req in the cycle after its ack unless it is issuing a new request.
//   - A request still high in the following IDLE cycle is arbitrated as new.
// dmem_address, data_to_dmem and req_gnt are registered outputs; req_ack and the strobes are decoded from the FSM state.
// TESTING
// Read, core0 only, addr=0x05C, mem[0x05C]=0xDEADBEEF, MEM_LAT=1 ->
//   dmem_rd_en 1 cycle after req; req_ack[0] 3 cycles after req; req_rdata=0xDEADBEEF.
// Both cores read at t=0, rr_ptr=0 ->
//   core0 acked at t=3, core1 strobe at t=5, core1 acked at t=7; rr_ptr ends at 0.
// Core1 write 0x12345678 to 0x3FF, then core0 read 0x3FF ->
//   dmem_wr_en with data_to_dmem=0x12345678; core0 then reads back 0x12345678.
// Both cores continuously requesting for 8 transactions -> grants alternate 0,1,0,1,...; no requester starved.
// reset=0 during WAIT of a read ->
//   all outputs 0 in the same cycle; no req_ack after release; next request is served from rr_ptr=0.
// Core0 with req_rd=req_wr=1, MEM_LAT=3 -> only dmem_wr_en pulses; ack at t+5; req_rdata unchanged.

Source files
------------

// File: rtl/dmem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the shared data-memory arbiter.
interface dmem_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]             req_rd;
  logic [NUM_REQ-1:0]             req_wr;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_gnt;
  logic [NUM_REQ-1:0]             req_ack;
  logic [DATA_W-1:0]              req_rdata;
  logic                           dmem_rd_en;
  logic                           dmem_wr_en;
  logic [ADDR_W-1:0]              dmem_address;
  logic [DATA_W-1:0]              data_to_dmem;
  logic [DATA_W-1:0]              data_from_dmem;

  // Arbiter view: serves the requesters and drives the memory port.
  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, data_from_dmem,
    output req_gnt, req_ack, req_rdata, dmem_rd_en, dmem_wr_en,
           dmem_address, data_to_dmem
  );

  // Environment view: the caches plus the memory model.
  modport master (
    output req_rd, req_wr, req_addr, req_wdata, data_from_dmem,
    input  req_gnt, req_ack, req_rdata, dmem_rd_en, dmem_wr_en,
           dmem_address, data_to_dmem
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ L1 caches.
// One transaction at a time: IDLE -> ACCESS -> WAIT (MEM_LAT) -> RESP.
module dmem_bus_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  dmem_bus_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 op_wr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [CNT_W-1:0]     lat_cnt_q;

  logic [NUM_REQ-1:0]   active_c;
  logic                 pick_vld_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic [IDX_W:0]       cand_c;

  assign active_c = bus.req_rd | bus.req_wr;

  // First active requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_idx_c = '0;
    cand_c     = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand_c = (IDX_W+1)'(rr_ptr_q) + (IDX_W+1)'(k);
      if (cand_c >= (IDX_W+1)'(NUM_REQ)) begin
        cand_c = cand_c - (IDX_W+1)'(NUM_REQ);
      end
      if (active_c[cand_c[IDX_W-1:0]]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = cand_c[IDX_W-1:0];
      end
    end
  end

  // Transaction FSM; latches the winner's op/addr/wdata so later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      lat_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld_c) begin
            owner_q <= pick_idx_c;
            gnt_q   <= NUM_REQ'(1) << pick_idx_c;
            // A simultaneous read and write from one requester is a write.
            op_wr_q <= bus.req_wr[pick_idx_c];
            addr_q  <= bus.req_addr[pick_idx_c];
            wdata_q <= bus.req_wr[pick_idx_c] ? bus.req_wdata[pick_idx_c] : '0;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          lat_cnt_q <= CNT_W'(MEM_LAT);
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt_q <= lat_cnt_q - CNT_W'(1);
          if (lat_cnt_q == CNT_W'(1)) begin
            if (!op_wr_q) begin
              rdata_q <= bus.data_from_dmem;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          rr_ptr_q <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          gnt_q    <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes and ack are pure decodes of the state register; the rest are registers.
  assign bus.dmem_rd_en   = (state_q == S_ACCESS) && !op_wr_q;
  assign bus.dmem_wr_en   = (state_q == S_ACCESS) &&  op_wr_q;
  assign bus.req_ack      = (state_q == S_RESP) ? gnt_q : '0;
  assign bus.req_gnt      = gnt_q;
  assign bus.dmem_address = addr_q;
  assign bus.data_to_dmem = wdata_q;
  assign bus.req_rdata    = rdata_q;

endmodule
